lab1_sweep_checker: RTL and testbench
=====================================

Name: lab1_sweep_checker

Overview:
- Hardware sequencer for exhaustive self-checking of the three lab1 2-bit datapath implementations: functional, executional and block-diagram.
- Drives one shared 6-bit input vector {i1,i0,b1,b0,a1,a0} to all three units.
- Holds each vector for a fixed settle time, samples the three 2-bit results and counts disagreements.
- Sits between a start/status interface (board switch/LED or top-level bench) and the three datapath instances.

Parameters:
- VEC_W, 6: width of the driven input vector; sweep covers 0 .. 2^VEC_W-1.
- OUT_W, 2: width of each unit's result.
- SETTLE_CYC, 2: extra cycles each vector is held before sampling (legal 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- vec_out  output  VEC_W  vector to all three units; bit0=a0, bit1=a1, bit2=b0, bit3=b1, bit4=i0, bit5=i1.
- f_func  input  OUT_W  functional unit result.
- f_exe  input  OUT_W  executional unit result.
- f_blk  input  OUT_W  block-diagram unit result.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  VEC_W+1  number of vectors with any disagreement (max 64, no saturation needed).
- first_err_valid  output  1  at least one mismatch recorded this sweep.
- first_err_vec  output  VEC_W  vector of the first mismatch.

Behaviour:
- Reset (async assert, synchronous-safe deassert): state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0, settle counter=0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 at a rising edge -> SETTLE.
  - On that edge: vec_out=0, settle counter=SETTLE_CYC, all result registers cleared, busy=1, done=0.
- SETTLE: counter decrements each cycle; when it reaches 0 -> CHECK. vec_out is stable throughout.
- CHECK (one cycle): sample f_func, f_exe and f_blk at the rising edge.
  - Mismatch = not (f_func==f_exe && f_exe==f_blk).
  - On mismatch: err_count+1; if first_err_valid==0, capture first_err_vec=vec_out and set first_err_valid=1.
  - If vec_out==2^VEC_W-1 -> DONE: busy=0, done=1, pass=(final err_count==0), vec_out held at 63.
  - Otherwise vec_out+1, counter reloaded with SETTLE_CYC -> SETTLE.
- Timing: each vector is presented for exactly SETTLE_CYC+1 cycles. With defaults, done rises 64*3=192 cycles after the start-accept edge.
- Comparison and the count update happen in the same CHECK cycle. The final vector's mismatch is included in pass.
- start while busy: ignored; no restart, no counter disturbance.
- start in DONE: treated as in IDLE; clears results, restarts at vector 0 and drops done on the accept edge.
- vec_out wrap: never wraps past 2^VEC_W-1 within a sweep; the next sweep resets it to 0 explicitly.
- Reset mid-sweep: immediate return to the reset values; partial results are discarded.
- Inputs are sampled only in CHECK; values in SETTLE are don't-care (glitches tolerated).

Test Plan:
- Equal units: tie f_func=f_exe=f_blk to a common model of vec_out, pulse start -> busy for 192 cycles, then done=1, pass=1, err_count=0, first_err_valid=0, vec_out=63.
- Single fault: force f_blk bit0 inverted only when vec_out==6'h2A -> done with pass=0, err_count=1, first_err_vec=6'h2A, first_err_valid=1.
- Multiple faults: f_exe wrong for vec 5 and 17, f_blk wrong for vec 17 and 63 -> err_count=3, first_err_vec=5, pass=0; the vec-63 error is counted.
- Settle check: with SETTLE_CYC=2, the model output changes one cycle after vec_out changes and is garbage otherwise -> pass=1. Every vec_out value is held exactly 3 cycles.
- Start handling: start re-pulsed at cycle 50 -> ignored, done still at cycle 192. start pulsed in DONE -> done=0, err_count=0, vec_out=0 on the next edge.
- Reset mid-sweep: assert rst_n=0 at cycle 100 with err_count=2 -> all outputs zero immediately (async). start after release gives a full fresh sweep.

Source files
------------

// File: rtl/lab1_sweep_checker.sv
// Exhaustive sweep sequencer: drives every input vector to the three lab1 2-bit
// datapath units, holds it to settle, then compares their results and tallies disagreements.
module lab1_sweep_checker #(
    parameter int VEC_W      = 6,
    parameter int OUT_W      = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [VEC_W-1:0]   vec_out,
    input  logic [OUT_W-1:0]   f_func,
    input  logic [OUT_W-1:0]   f_exe,
    input  logic [OUT_W-1:0]   f_blk,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [VEC_W:0]     err_count,
    output logic               first_err_valid,
    output logic [VEC_W-1:0]   first_err_vec
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [VEC_W-1:0] VEC_LAST  = {VEC_W{1'b1}};
    localparam logic [VEC_W-1:0] VEC_ZERO  = {VEC_W{1'b0}};
    localparam logic [VEC_W:0]   ERR_ZERO  = {(VEC_W+1){1'b0}};

    logic [1:0]       state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [VEC_W:0]   err_q, err_d;
    logic             fe_valid_q, fe_valid_d;
    logic [VEC_W-1:0] fe_vec_q, fe_vec_d;
    logic             mism_s;

    function automatic logic units_disagree(input logic [OUT_W-1:0] a,
                                            input logic [OUT_W-1:0] b,
                                            input logic [OUT_W-1:0] c);
        return !((a == b) && (b == c));
    endfunction

    // Next-state logic for the sweep sequencer and result registers
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fe_valid_d = fe_valid_q;
        fe_vec_d   = fe_vec_q;
        mism_s     = units_disagree(f_func, f_exe, f_blk);

        case (state_q)
            S_IDLE, S_DONE: begin
                // A start in DONE behaves exactly like one in IDLE: fresh sweep
                if (start) begin
                    state_d    = S_SETTLE;
                    vec_d      = VEC_ZERO;
                    cnt_d      = SETTLE_LD;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = ERR_ZERO;
                    fe_valid_d = 1'b0;
                    fe_vec_d   = VEC_ZERO;
                end else begin
                    state_d = state_q;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_CHECK: begin
                if (mism_s) begin
                    err_d = err_q + {{VEC_W{1'b0}}, 1'b1};
                    if (!fe_valid_q) begin
                        fe_valid_d = 1'b1;
                        fe_vec_d   = vec_q;
                    end else begin
                        fe_valid_d = fe_valid_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (vec_q == VEC_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == ERR_ZERO);
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + {{(VEC_W-1){1'b0}}, 1'b1};
                    cnt_d   = SETTLE_LD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= VEC_ZERO;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= ERR_ZERO;
            fe_valid_q <= 1'b0;
            fe_vec_q   <= VEC_ZERO;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fe_valid_q <= fe_valid_d;
            fe_vec_q   <= fe_vec_d;
        end
    end

    assign vec_out         = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_vec   = fe_vec_q;

endmodule

// File: tb/tb_lab1_sweep_checker.sv
// Bench for lab1_sweep_checker: a behavioural model of the three units with
// selectable fault injection; a scoreboard queue holds expected sweep results.
module tb_lab1_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] vec_out;
    logic [1:0] f_func, f_exe, f_blk;
    logic       busy, done, pass;
    logic [6:0] err_count;
    logic       first_err_valid;
    logic [5:0] first_err_vec;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int cyc    = 0;
    logic [5:0] vec_prev = 6'd0;

    typedef struct {
        int err;
        int fvalid;
        int fvec;
        int pass;
    } exp_t;
    exp_t sb_q[$];

    lab1_sweep_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out),
        .f_func(f_func), .f_exe(f_exe), .f_blk(f_blk),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        vec_prev <= vec_out;
    end

    function automatic logic [1:0] golden(input logic [5:0] v);
        logic [1:0] a, b;
        a = v[1:0];
        b = v[3:2];
        case (v[5:4])
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Unit model: mode 1 single fault, mode 2 multiple faults, mode 3 first-cycle glitch
    always_comb begin
        f_func = golden(vec_out);
        f_exe  = golden(vec_out);
        f_blk  = golden(vec_out);
        case (mode)
            1: if (vec_out == 6'h2A) f_blk = golden(vec_out) ^ 2'b01;
            2: begin
                if (vec_out == 6'd5 || vec_out == 6'd17) f_exe = golden(vec_out) ^ 2'b10;
                if (vec_out == 6'd17 || vec_out == 6'd63) f_blk = golden(vec_out) ^ 2'b01;
            end
            3: if (vec_out != vec_prev) begin
                f_exe = ~golden(vec_out);
                f_blk = golden(vec_out) ^ 2'b01;
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_fvalid"}, int'(first_err_valid), 0);
        check({tag, "_fvec"}, int'(first_err_vec), 0);
        check({tag, "_vec"}, int'(vec_out), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic push_exp(input int e, input int fv, input int fvec, input int p);
        exp_t x;
        x.err = e; x.fvalid = fv; x.fvec = fvec; x.pass = p;
        sb_q.push_back(x);
    endtask

    // Monitor: per-vector hold length, sweep latency, scoreboard compare on done rise
    initial begin
        logic busy_prev = 1'b0, done_prev = 1'b0;
        logic [5:0] last_vec = 6'd0;
        int run = 0, start_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                if (busy_prev) begin
                    if (vec_out == last_vec) run++;
                    else begin
                        check("hold_cycles", run, 3);
                        run = 1;
                    end
                end else begin
                    run = 1;
                    start_cyc = cyc;
                end
            end else if (busy_prev && done) begin
                check("hold_last", run, 3);
            end
            if (done && !done_prev) begin
                check("sb_nonempty", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("err_count", int'(err_count), e.err);
                    check("first_err_valid", int'(first_err_valid), e.fvalid);
                    check("first_err_vec", int'(first_err_vec), e.fvec);
                    check("pass", int'(pass), e.pass);
                    check("vec_final", int'(vec_out), 63);
                    check("busy_at_done", int'(busy), 0);
                    check("latency", cyc - start_cyc, 192);
                end
            end
            busy_prev = busy;
            done_prev = done;
            last_vec  = vec_out;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Equal units, with a start re-pulse at cycle 50 that must be ignored
        mode = 0;
        push_exp(0, 0, 0, 1);
        pulse_start();
        repeat (49) @(negedge clk);
        pulse_start();
        check("busy_after_repulse", int'(busy), 1);
        wait_done("equal");

        // Single fault at vector 0x2A
        repeat (3) @(negedge clk);
        mode = 1;
        push_exp(1, 1, 8'h2A, 0);
        pulse_start();
        wait_done("single");

        // Multiple faults, including the final vector
        repeat (3) @(negedge clk);
        mode = 2;
        push_exp(3, 1, 5, 0);
        pulse_start();
        wait_done("multi");
        repeat (3) @(negedge clk);
        check("done_held", int'(done), 1);
        check("err_held", int'(err_count), 3);

        // Start while in DONE, settle-glitch model
        mode = 3;
        push_exp(0, 0, 0, 1);
        pulse_start();
        check("restart_done", int'(done), 0);
        check("restart_err", int'(err_count), 0);
        check("restart_vec", int'(vec_out), 0);
        check("restart_busy", int'(busy), 1);
        wait_done("settle");

        // Reset mid-sweep after two errors
        repeat (3) @(negedge clk);
        mode = 2;
        pulse_start();
        repeat (98) @(negedge clk);
        check("mid_err", int'(err_count), 2);
        check("mid_fvec", int'(first_err_vec), 5);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh sweep after reset
        mode = 0;
        push_exp(0, 0, 0, 1);
        pulse_start();
        wait_done("fresh");
        repeat (3) @(negedge clk);

        check("sb_drained", int'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
